// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle for one arbiter port (CPU or video fetch).
// The requester drives the master side; the arbiter drives the slave side.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// B (video fetch) normally wins contention, but after MAX_STREAK consecutive
// B grants while A (CPU) waits, A is served. Every access is one ISSUE cycle
// followed by one IDLE cycle; read data returns two cycles after the grant.
module ram_port_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int MAX_STREAK = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_port_arbiter_if.slave     a_port,
    ram_port_arbiter_if.slave     b_port,
    output logic                  ram_clken,
    output logic                  ram_wren,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W-1:0]     ram_data,
    input  logic [DATA_W-1:0]     ram_q
);

    // A zero-width counter is illegal, so MAX_STREAK=0 keeps one bit that never leaves 0.
    localparam int STREAK_W = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_A = 2'd1,
        ISSUE_B = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                cmd_we_q,    cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [STREAK_W-1:0] streak_q,    streak_d;
    logic                a_pend_q,    a_pend_d;
    logic                b_pend_q,    b_pend_d;
    logic                a_rvalid_q,  a_rvalid_d;
    logic                b_rvalid_q,  b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q,   a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q,   b_rdata_d;

    logic a_win;
    logic b_win;

    // A wins when alone, or when B has already had MAX_STREAK turns while A waited.
    assign a_win = a_port.req && (!b_port.req || (streak_q == STREAK_MAX));
    assign b_win = b_port.req && !a_win;

    // Next-state, command capture, streak bookkeeping and read-data capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        streak_d    = streak_q;
        a_pend_d    = 1'b0;
        b_pend_d    = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (!a_port.req) begin
                    streak_d = '0;
                end
                if (a_win) begin
                    state_d     = ISSUE_A;
                    cmd_we_d    = a_port.we;
                    cmd_addr_d  = a_port.addr;
                    cmd_wdata_d = a_port.wdata;
                    streak_d    = '0;
                end else if (b_win) begin
                    state_d     = ISSUE_B;
                    cmd_we_d    = b_port.we;
                    cmd_addr_d  = b_port.addr;
                    cmd_wdata_d = b_port.wdata;
                    if (a_port.req && (streak_q < STREAK_MAX)) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end
            ISSUE_A: begin
                state_d  = IDLE;
                a_pend_d = !cmd_we_q;
            end
            ISSUE_B: begin
                state_d  = IDLE;
                b_pend_d = !cmd_we_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ram_q is valid the cycle after a read issue; the two ports capture independently.
        if (a_pend_q) begin
            a_rdata_d  = ram_q;
            a_rvalid_d = 1'b1;
        end
        if (b_pend_q) begin
            b_rdata_d  = ram_q;
            b_rvalid_d = 1'b1;
        end
    end

    // State and datapath registers; reset overrides every update.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            streak_q    <= '0;
            a_pend_q    <= 1'b0;
            b_pend_q    <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            streak_q    <= streak_d;
            a_pend_q    <= a_pend_d;
            b_pend_q    <= b_pend_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    // Outputs are flops or decodes of the registered state only.
    assign ram_clken   = (state_q == ISSUE_A) || (state_q == ISSUE_B);
    assign ram_wren    = ram_clken && cmd_we_q;
    assign ram_address = cmd_addr_q;
    assign ram_data    = cmd_wdata_q;

    assign a_port.gnt    = (state_q == ISSUE_A);
    assign b_port.gnt    = (state_q == ISSUE_B);
    assign a_port.rvalid = a_rvalid_q;
    assign b_port.rvalid = b_rvalid_q;
    assign a_port.rdata  = a_rdata_q;
    assign b_port.rdata  = b_rdata_q;

endmodule
